// File: rtl/display_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | display_scan_controller: two-digit 7-segment scan with blanking gaps.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module display_scan_controller #(
  parameter int DIV   = 50000,
  parameter int BLANK = 500
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  output logic       selector,
  output logic [1:0] digit_en,
  output logic       frame_tick
);

  localparam int c_max_div = (DIV > BLANK) ? DIV : BLANK;
  localparam int c_max     = (c_max_div > 2) ? c_max_div : 2;
  localparam int c_cw      = $clog2(c_max);

  localparam logic [c_cw-1:0] c_div_last   = c_cw'(DIV - 1);
  localparam logic [c_cw-1:0] c_blank_last = c_cw'((BLANK > 0) ? (BLANK - 1) : 0);

  localparam logic [2:0] c_idle    = 3'd0;
  localparam logic [2:0] c_show_n  = 3'd1;
  localparam logic [2:0] c_blank_r = 3'd2;
  localparam logic [2:0] c_show_r  = 3'd3;
  localparam logic [2:0] c_blank_n = 3'd4;

  logic [2:0]      r_state;
  logic [c_cw-1:0] r_count;
  logic            r_selector;
  logic [1:0]      r_digit_en;
  logic            r_frame_tick;

  logic [2:0]      w_next_state;
  logic [c_cw-1:0] w_next_count;
  logic            w_next_tick;

  always_comb begin
    w_next_state = r_state;
    w_next_count = r_count + c_cw'(1);
    if (!enable) begin
      w_next_state = c_idle;
      w_next_count = '0;
    end else begin
      case (r_state)
        c_idle: begin
          w_next_state = c_show_n;
          w_next_count = '0;
        end
        c_show_n: begin
          if (r_count == c_div_last) begin
            w_next_state = (BLANK == 0) ? c_show_r : c_blank_r;
            w_next_count = '0;
          end
        end
        c_blank_r: begin
          if (r_count == c_blank_last) begin
            w_next_state = c_show_r;
            w_next_count = '0;
          end
        end
        c_show_r: begin
          if (r_count == c_div_last) begin
            w_next_state = (BLANK == 0) ? c_show_n : c_blank_n;
            w_next_count = '0;
          end
        end
        c_blank_n: begin
          if (r_count == c_blank_last) begin
            w_next_state = c_show_n;
            w_next_count = '0;
          end
        end
        default: begin
          w_next_state = c_idle;
          w_next_count = '0;
        end
      endcase
    end
  end

  // The tick is decoded from the upcoming state so it lands on the frame's last cycle.
  always_comb begin
    w_next_tick = 1'b0;
    if (BLANK == 0) begin
      w_next_tick = (w_next_state == c_show_r) && (w_next_count == c_div_last);
    end else begin
      w_next_tick = (w_next_state == c_blank_n) && (w_next_count == c_blank_last);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= c_idle;
      r_count      <= '0;
      r_selector   <= 1'b0;
      r_digit_en   <= 2'b11;
      r_frame_tick <= 1'b0;
    end else begin
      r_state      <= w_next_state;
      r_count      <= w_next_count;
      r_selector   <= (w_next_state == c_blank_r) || (w_next_state == c_show_r);
      r_frame_tick <= w_next_tick;
      case (w_next_state)
        c_show_n: r_digit_en <= 2'b10;
        c_show_r: r_digit_en <= 2'b01;
        default:  r_digit_en <= 2'b11;
      endcase
    end
  end

  assign selector   = r_selector;
  assign digit_en   = r_digit_en;
  assign frame_tick = r_frame_tick;

endmodule
`default_nettype wire

// File: tb/tb_display_scan_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_display_scan_controller: directed checks of scan sequence and ticks.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_display_scan_controller;

  logic       clk;
  logic       rst_a, en_a, sel_a, tick_a;
  logic [1:0] den_a;
  logic       rst_b, en_b, sel_b, tick_b;
  logic [1:0] den_b;

  int n_checks = 0;
  int n_errors = 0;

  // Observation vector: {selector, digit_en[1:0], frame_tick}
  localparam logic [3:0] c_idle_v  = 4'b0110;
  localparam logic [3:0] c_shown_v = 4'b0100;
  localparam logic [3:0] c_blkr_v  = 4'b1110;
  localparam logic [3:0] c_showr_v = 4'b1010;
  localparam logic [3:0] c_blkn_v  = 4'b0110;
  localparam logic [3:0] c_last_v  = 4'b0111;
  localparam logic [3:0] c_srlst_v = 4'b1011;

  display_scan_controller #(.DIV(4), .BLANK(2)) u_dut_a (
    .clock      (clk),
    .reset      (rst_a),
    .enable     (en_a),
    .selector   (sel_a),
    .digit_en   (den_a),
    .frame_tick (tick_a)
  );

  display_scan_controller #(.DIV(3), .BLANK(0)) u_dut_b (
    .clock      (clk),
    .reset      (rst_b),
    .enable     (en_b),
    .selector   (sel_b),
    .digit_en   (den_b),
    .frame_tick (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %b expected %b", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_a(input int p);
    if (p < 4)       return c_shown_v;
    else if (p < 6)  return c_blkr_v;
    else if (p < 10) return c_showr_v;
    else if (p == 10) return c_blkn_v;
    else             return c_last_v;
  endfunction

  function automatic logic [3:0] exp_b(input int p);
    if (p < 3)       return c_shown_v;
    else if (p < 5)  return c_showr_v;
    else             return c_srlst_v;
  endfunction

  function automatic logic [3:0] obs_a();
    return {sel_a, den_a, tick_a};
  endfunction

  function automatic logic [3:0] obs_b();
    return {sel_b, den_b, tick_b};
  endfunction

  logic prev_sel;

  initial begin
    rst_a = 1'b1; en_a = 1'b1;
    rst_b = 1'b1; en_b = 1'b1;

    @(negedge clk);
    check("reset_a", obs_a(), c_idle_v);
    @(negedge clk);
    check("reset_hold_a", obs_a(), c_idle_v);
    rst_a = 1'b0;
    #1 check("idle_after_release", obs_a(), c_idle_v);

    for (int p = 0; p < 24; p++) begin
      @(negedge clk);
      check("frame_a", obs_a(), exp_a(p % 12));
    end

    // Run into the second SHOW_R cycle, then drop enable.
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      check("pre_drop", obs_a(), exp_a(p));
    end
    en_a = 1'b0;
    @(negedge clk);
    check("drop_idle", obs_a(), c_idle_v);
    @(negedge clk);
    check("drop_idle2", obs_a(), c_idle_v);
    en_a = 1'b1;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk);
      check("reenable", obs_a(), exp_a(p));
    end

    // Now in the first BLANK_R cycle: hit reset between edges.
    #2 rst_a = 1'b1;
    #1 check("async_reset", obs_a(), c_idle_v);
    @(negedge clk);
    check("reset_mid_hold", obs_a(), c_idle_v);
    rst_a = 1'b0;
    #1 check("idle_after_rst2", obs_a(), c_idle_v);
    for (int p = 0; p < 12; p++) begin
      @(negedge clk);
      check("restart_a", obs_a(), exp_a(p));
    end

    check("reset_b", obs_b(), c_idle_v);
    rst_b = 1'b0;
    #1 check("idle_b", obs_b(), c_idle_v);
    for (int p = 0; p < 18; p++) begin
      @(negedge clk);
      check("frame_b", obs_b(), exp_b(p % 6));
    end

    prev_sel = sel_a;
    for (int i = 0; i < 1000; i++) begin
      en_a = ($urandom_range(0, 15) != 0);
      @(negedge clk);
      check("no_both_lit", {3'b000, den_a != 2'b00}, 4'b0001);
      if (den_a != 2'b11)
        check("sel_stable", {3'b000, sel_a}, {3'b000, prev_sel});
      if (tick_a)
        check("tick_in_blank_n", {sel_a, den_a, 1'b1}, c_last_v);
      prev_sel = sel_a;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
